// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path.
//   state_e  : scan FSM state (digit lit / inter-digit blanking gap)
//   SEG_OFF  : all segments dark (active-low)
//   DIG_OFF  : all digit enables off (active-low)
//   HEX_SEG  : hex digit -> active-low {g,f,e,d,c,b,a} pattern
package seg7_pkg;

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
//   hex_i : 4-bit hex digit
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[hex_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A written value sits in a pending buffer and is promoted to the displayed
// (active) buffer only at the frame boundary, so a frame never tears.
//   sys_clk    : clock, rising edge
//   scan_rst   : synchronous active-high reset
//   disp_in    : 16-bit value, nibble k -> digit k (digit 0 rightmost)
//   blank_in   : per-digit blank mask, 1 = dark
//   disp_we    : one-cycle strobe capturing disp_in/blank_in into pending
//   Y_r        : segments {g..a}, active-low, registered
//   DIG_r      : digit enables, active-low, registered
//   frame_done : one-cycle pulse on the first cycle after digit 3 ends
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        scan_rst,
  input  logic [15:0] disp_in,
  input  logic [3:0]  blank_in,
  input  logic        disp_we,
  output logic [6:0]  Y_r,
  output logic [3:0]  DIG_r,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX0 = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
  localparam int unsigned CW       = $clog2(CNT_MAX);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_blk_q, pend_blk_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_blk_q, act_blk_d;
  logic [6:0]    y_d;
  logic [3:0]    dig_d;
  logic          fd_d;
  logic [3:0]    nib_d;
  logic [6:0]    seg_d;

  seg7_hex_decode u_dec (
    .hex_i (nib_d),
    .seg_o (seg_d)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CW'(1);
    fd_d       = 1'b0;
    pend_val_d = pend_val_q;
    pend_blk_d = pend_blk_q;
    act_val_d  = act_val_q;
    act_blk_d  = act_blk_q;

    // idx advances when a digit's SHOW ends, so GAP->SHOW never touches it;
    // this lets the reset-initial GAP lead into digit 0 with no special case.
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          fd_d    = (idx_q == 2'd3);
          state_d = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
        end
      end
      default: begin
        if ((GAP_CYCLES == 0) || (cnt_q == GAP_LAST)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end
      end
    endcase

    if (disp_we) begin
      pend_val_d = disp_in;
      pend_blk_d = blank_in;
    end

    // Promotion uses the pre-edge pending contents; a same-edge write waits a frame.
    if (fd_d) begin
      act_val_d = pend_val_q;
      act_blk_d = pend_blk_q;
    end

    // Outputs are decoded from next-state values so the registered outputs
    // line up with the state register in the same cycle.
    nib_d = act_val_d[{idx_d, 2'b00} +: 4];
    if (state_d == ST_SHOW) begin
      dig_d = ~(4'b0001 << idx_d);
      y_d   = act_blk_d[idx_d] ? SEG_OFF : seg_d;
    end else begin
      dig_d = DIG_OFF;
      y_d   = SEG_OFF;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (scan_rst) begin
      state_q    <= ST_GAP;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_val_q <= '0;
      pend_blk_q <= '0;
      act_val_q  <= '0;
      act_blk_q  <= '0;
      Y_r        <= SEG_OFF;
      DIG_r      <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_val_q <= pend_val_d;
      pend_blk_q <= pend_blk_d;
      act_val_q  <= act_val_d;
      act_blk_q  <= act_blk_d;
      Y_r        <= y_d;
      DIG_r      <= dig_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // DUT A: SCAN_DIV=4, GAP_CYCLES=2
  logic        rst_a = 1'b1;
  logic [15:0] din_a = '0;
  logic [3:0]  blk_a = '0;
  logic        we_a  = 1'b0;
  logic [6:0]  y_a;
  logic [3:0]  dig_a;
  logic        fd_a;

  // DUT B: SCAN_DIV=4, GAP_CYCLES=0
  logic        rst_b = 1'b1;
  logic [15:0] din_b = '0;
  logic [3:0]  blk_b = '0;
  logic        we_b  = 1'b0;
  logic [6:0]  y_b;
  logic [3:0]  dig_b;
  logic        fd_b;

  seg7_scan_driver #(.SCAN_DIV(4), .GAP_CYCLES(2)) dut_a (
    .sys_clk(sys_clk), .scan_rst(rst_a), .disp_in(din_a), .blank_in(blk_a),
    .disp_we(we_a), .Y_r(y_a), .DIG_r(dig_a), .frame_done(fd_a)
  );

  seg7_scan_driver #(.SCAN_DIV(4), .GAP_CYCLES(0)) dut_b (
    .sys_clk(sys_clk), .scan_rst(rst_b), .disp_in(din_b), .blank_in(blk_b),
    .disp_we(we_b), .Y_r(y_b), .DIG_r(dig_b), .frame_done(fd_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [6:0] y;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0]     din;
    logic [3:0]      blk;
    logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
  } row_t;

  exp_t sbq[$];
  row_t rows[6];

  // reference model state (t = edges since the reset edge)
  int          ta, tb;
  logic [15:0] pv, av;
  logic [3:0]  pb, ab;

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Timeline model: first digit lit at t=lead, each digit slot is S lit + G dark.
  function automatic bit fd_at(input int t, input int s, input int g);
    int lead = (g == 0) ? 1 : g;
    int p    = s + g;
    return (t > lead) && (((t - lead + g) % (4 * p)) == 0);
  endfunction

  function automatic exp_t expect_at(input int t, input int s, input int g,
                                     input logic [15:0] v, input logic [3:0] b);
    exp_t e;
    int lead = (g == 0) ? 1 : g;
    int p    = s + g;
    int slot;
    e.y   = 7'h7F;
    e.dig = 4'b1111;
    e.fd  = fd_at(t, s, g);
    if (t >= lead && ((t - lead) % p) < s) begin
      slot  = ((t - lead) / p) % 4;
      e.dig = ~(4'b0001 << slot);
      e.y   = b[slot] ? 7'h7F : seg_ref(v[slot*4 +: 4]);
    end
    return e;
  endfunction

  task automatic check(input string nm, input int t, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  task automatic tick_a(input logic rst, input logic we, input logic [15:0] d, input logic [3:0] b);
    exp_t e;
    rst_a = rst; we_a = we; din_a = d; blk_a = b;
    if (rst) begin
      ta = 0; pv = '0; av = '0; pb = '0; ab = '0;
    end else begin
      ta++;
      if (fd_at(ta, 4, 2)) begin av = pv; ab = pb; end
      if (we) begin pv = d; pb = b; end
    end
    sbq.push_back(expect_at(ta, 4, 2, av, ab));
    @(posedge sys_clk);
    #1;
    e = sbq.pop_front();
    check("A_Y_r", ta, {9'd0, y_a}, {9'd0, e.y});
    check("A_DIG_r", ta, {12'd0, dig_a}, {12'd0, e.dig});
    check("A_frame_done", ta, {15'd0, fd_a}, {15'd0, e.fd});
  endtask

  task automatic tick_b(input logic rst);
    exp_t e;
    rst_b = rst;
    if (rst) tb = 0; else tb++;
    sbq.push_back(expect_at(tb, 4, 0, 16'h0000, 4'b0000));
    @(posedge sys_clk);
    #1;
    e = sbq.pop_front();
    check("B_Y_r", tb, {9'd0, y_b}, {9'd0, e.y});
    check("B_DIG_r", tb, {12'd0, dig_b}, {12'd0, e.dig});
    check("B_frame_done", tb, {15'd0, fd_b}, {15'd0, e.fd});
  endtask

  task automatic wait_dig_a(input logic [3:0] pat);
    int n = 0;
    while (dig_a !== pat && n < 64) begin
      tick_a(1'b0, 1'b0, 16'h0, 4'h0);
      n++;
    end
    check("wait_DIG_r", ta, {12'd0, dig_a}, {12'd0, pat});
  endtask

  task automatic wait_fd_a();
    int n = 0;
    do begin
      tick_a(1'b0, 1'b0, 16'h0, 4'h0);
      n++;
    end while (fd_a !== 1'b1 && n < 64);
    check("wait_frame_done", ta, {15'd0, fd_a}, 16'd1);
  endtask

  initial begin
    logic [3:0] pat;
    int         first_fd;

    rows[0] = '{16'h12AF, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}};
    rows[1] = '{16'h8888, 4'b0101, {7'h00, 7'h7F, 7'h00, 7'h7F}};
    rows[2] = '{16'h0123, 4'b0000, {7'h40, 7'h79, 7'h24, 7'h30}};
    rows[3] = '{16'h4567, 4'b0000, {7'h19, 7'h12, 7'h02, 7'h78}};
    rows[4] = '{16'h89AB, 4'b0000, {7'h00, 7'h10, 7'h08, 7'h03}};
    rows[5] = '{16'hCDEF, 4'b0000, {7'h46, 7'h21, 7'h06, 7'h0E}};

    // Scenario 1: reset, free-run, first frame_done 24 cycles after release
    tick_a(1'b1, 1'b0, 16'h0, 4'h0);
    tick_a(1'b1, 1'b0, 16'h0, 4'h0);
    check("rst_Y_r", ta, {9'd0, y_a}, 16'h007F);
    check("rst_DIG_r", ta, {12'd0, dig_a}, 16'h000F);
    first_fd = -1;
    for (int i = 0; i < 30; i++) begin
      tick_a(1'b0, 1'b0, 16'h0, 4'h0);
      if (fd_a === 1'b1 && first_fd < 0) first_fd = ta;
    end
    check("first_fd_cycle", ta, 16'(first_fd), 16'd24);

    // Scenarios 2/3 + segment table: write mid-frame, check the next frame
    for (int r = 0; r < 6; r++) begin
      tick_a(1'b0, 1'b1, rows[r].din, rows[r].blk);
      wait_fd_a();
      for (int k = 0; k < 4; k++) begin
        pat = ~(4'b0001 << k);
        wait_dig_a(pat);
        check("row_seg", ta, {9'd0, y_a}, {9'd0, rows[r].seg[k]});
      end
    end

    // Scenario 4: write coinciding with the boundary edge is deferred a frame
    tick_a(1'b0, 1'b1, 16'h2222, 4'h0);
    while (!fd_at(ta + 1, 4, 2)) tick_a(1'b0, 1'b0, 16'h0, 4'h0);
    tick_a(1'b0, 1'b1, 16'h1111, 4'h0);
    check("boundary_fd", ta, {15'd0, fd_a}, 16'd1);
    wait_dig_a(4'b1110);
    check("boundary_old", ta, {9'd0, y_a}, 16'h0024);
    wait_fd_a();
    wait_dig_a(4'b1110);
    check("boundary_new", ta, {9'd0, y_a}, 16'h0079);

    // Scenario 5: reset while digit 2 is lit
    wait_dig_a(4'b1011);
    tick_a(1'b1, 1'b0, 16'h0, 4'h0);
    check("midrst_DIG_r", ta, {12'd0, dig_a}, 16'h000F);
    check("midrst_Y_r", ta, {9'd0, y_a}, 16'h007F);
    for (int i = 0; i < 30; i++) tick_a(1'b0, 1'b0, 16'h0, 4'h0);

    // Scenario 6: GAP_CYCLES=0 build
    tick_b(1'b1);
    tick_b(1'b0);
    check("nogap_first", tb, {12'd0, dig_b}, 16'h000E);
    for (int i = 0; i < 40; i++) tick_b(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
